// File: rtl/select_operator_pipe.sv
// select_operator_pipe: per-lane minuend/subtrahend selector feeding a 2-entry elastic buffer.
// Latency: a beat pushed into an empty buffer is presented on the outputs the following cycle.
// Backpressure: in_ready is a registered decode of occupancy (low when full); no comb path from out_ready.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              synchronous clear of buffered entries (wins over a same-cycle push)
//   in_valid/in_ready  input handshake; cont, d, num_p_*, num_n_* are sampled on push
//   cont               000 full, 001 packed, 010 force-positive, others zero output
//   d                  per-lane "select negative" bits (d[0] also steers full mode)
//   out_valid/out_ready output handshake; op_0, op_1, neg_sel show the head entry
module select_operator_pipe #(
  parameter int LANE_W  = 24,
  parameter int GUARD_W = 8,
  parameter int NLANE   = 2,
  localparam int W      = NLANE * LANE_W + (NLANE - 1) * GUARD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cont,
  input  logic [NLANE-1:0] d,
  input  logic [W-1:0]     num_p_0,
  input  logic [W-1:0]     num_p_1,
  input  logic [W-1:0]     num_n_0,
  input  logic [W-1:0]     num_n_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     op_0,
  output logic [W-1:0]     op_1,
  output logic [NLANE-1:0] neg_sel
);

  localparam int          STRIDE      = LANE_W + GUARD_W;
  localparam logic [2:0]  MODE_FULL   = 3'b000;
  localparam logic [2:0]  MODE_PACKED = 3'b001;
  localparam logic [2:0]  MODE_POS    = 3'b010;

  typedef struct packed {
    logic [W-1:0]     op0;
    logic [W-1:0]     op1;
    logic [NLANE-1:0] neg_sel;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [W-1:0]     w_lane_mask;  // 1 on lane bits, 0 on guard bits
  logic [W-1:0]     w_neg_mask;   // lane bits whose lane selects the negative source
  logic [W-1:0]     w_s0;
  logic [W-1:0]     w_s1;
  logic [NLANE-1:0] w_neg_sel;
  entry_t           w_new;

  always_comb begin
    w_lane_mask = '0;
    w_neg_mask  = '0;
    for (int i = 0; i < NLANE; i++) begin
      for (int b = 0; b < LANE_W; b++) begin
        w_lane_mask[i*STRIDE+b] = 1'b1;
        w_neg_mask[i*STRIDE+b]  = d[i];
      end
    end
  end

  always_comb begin
    w_s0      = '0;
    w_s1      = '0;
    w_neg_sel = '0;
    case (cont)
      MODE_FULL: begin
        w_s0      = d[0] ? num_n_0 : num_p_0;
        w_s1      = d[0] ? num_n_1 : num_p_1;
        w_neg_sel = {NLANE{d[0]}};
      end
      MODE_PACKED: begin
        // Guard bits fall out as zero because neither mask covers them.
        w_s0      = (num_n_0 & w_neg_mask) | (num_p_0 & w_lane_mask & ~w_neg_mask);
        w_s1      = (num_n_1 & w_neg_mask) | (num_p_1 & w_lane_mask & ~w_neg_mask);
        w_neg_sel = d;
      end
      MODE_POS: begin
        w_s0 = num_p_0;
        w_s1 = num_p_1;
      end
      default: begin
        w_s0 = '0;
        w_s1 = '0;
      end
    endcase
  end

  // The downstream subtractor expects the selected pair swapped.
  always_comb begin
    w_new         = '0;
    w_new.op0     = w_s1;
    w_new.op1     = w_s0;
    w_new.neg_sel = w_neg_sel;
  end

  // ---------------------------------------------------------------------------
  // 2-entry elastic buffer: head register drives the outputs, tail holds the
  // second entry only while the buffer is full.
  // ---------------------------------------------------------------------------
  logic [1:0] r_count;
  entry_t     r_head;
  entry_t     r_tail;
  logic       w_push;
  logic       w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_new;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_new;
          end else if (w_push) begin
            r_tail  <= w_new;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign op_0    = r_head.op0;
  assign op_1    = r_head.op1;
  assign neg_sel = r_head.neg_sel;

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n) r_count != 2'd3);

endmodule

// File: doc/select_operator_pipe.md
Name: select_operator_pipe

Overview:
- Parametrised, pipelined successor to the MAF operand selector.
- Each cycle it takes positive and negative partial-sum pairs plus per-lane sign-decision bits, and selects the minuend/subtrahend per lane according to the precision mode.
- Selected operands pass through a 2-entry elastic buffer under a valid/ready handshake.
- Sits between the adder-tree/compare stage and the final subtractor.

Parameters:
- LANE_W, 24: width of one packed lane.
- GUARD_W, 8: zero gap between adjacent lanes.
- NLANE, 2: lane count in packed mode.
- W, NLANE*LANE_W+(NLANE-1)*GUARD_W (=56): full operand width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of buffered entries.
- in_valid  in  1  input beat present.
- in_ready  out  1  buffer can accept a beat.
- cont  in  3  mode: 000 full, 001 packed, 010 force-positive, others = zero output.
- d  in  NLANE  per-lane "select negative" bit; d[0] also drives full mode.
- num_p_0, num_p_1, num_n_0, num_n_1  in  W each  positive/negative operand pairs.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts.
- op_0  out  W  minuend.
- op_1  out  W  subtrahend.
- neg_sel  out  NLANE  per-lane record of which source was selected.

Behaviour:
- Selection (combinational, before the buffer). Let s0 and s1 be the selected num_*_0 and num_*_1.
  - Full (000): s0/s1 are all W bits of num_n_* if d[0]=1, else num_p_*.
  - Packed (001): lane i occupies bits [i*(LANE_W+GUARD_W)+LANE_W-1 : i*(LANE_W+GUARD_W)].
    - Lane i takes num_n_* if d[i]=1, else num_p_*.
    - Guard bits are forced to 0.
  - Force-positive (010): s0/s1 = num_p_0/num_p_1.
  - Other modes: s0 = s1 = 0.
  - Swap is mandatory: op_0 = s1, op_1 = s0.
  - neg_sel: full mode gives {NLANE{d[0]}}; packed mode gives d; all other modes give 0.
- Buffer:
  - 2-entry FIFO with registered outputs; count in {0,1,2}.
  - in_ready = (count != 2). It is a pure register decode with no combinational path from out_ready.
  - out_valid = (count != 0).
  - op_0, op_1 and neg_sel always present the head entry.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Latency: a beat pushed in cycle N is visible at the outputs in cycle N+1 when the buffer was empty.
  - Simultaneous push and pop at count=1: count stays 1 and the new beat becomes head the next cycle.
  - At count=2 no push occurs, because in_ready=0. A pop drops count to 1 and in_ready rises the next cycle.
  - Pop at count=0 is impossible (out_valid=0). Push at count=2 is ignored and never overwrites.
  - Order is strictly FIFO and no beat is duplicated.
- Mode and d are sampled with the data on the push cycle. Changes while a beat is held do not affect stored entries.
- flush:
  - Sets count to 0 on the next edge, so out_valid=0 and in_ready=1.
  - A push in the same cycle is discarded; flush wins.
- Reset (rst_n=0, asynchronous):
  - count=0, out_valid=0, in_ready=1.
  - op_0=op_1=0, neg_sel=0; entry storage cleared.
  - Reset asserted mid-transfer drops all entries immediately.
  - Deassertion is used synchronously (reset synchroniser lives upstream).

Test Plan:
- Full mode: cont=000, d=01, num_n_0=0x11, num_n_1=0x22 (upper bits 0), out_ready=1 -> one cycle later out_valid=1, op_0=0x22, op_1=0x11, neg_sel=11.
- Packed mode:
  - Stimulus: cont=001, d=10; num_p_*=all ones; num_n_*=0xAAAAAA in bits [55:32], ones elsewhere.
  - Response: op_0=op_1=0xAAAAAA_00_FFFFFF (bits 31:24 zero), neg_sel=10.
- Modes 010 and 101, with num_n = all ones and num_p_0=5, num_p_1=9:
  - 010 -> op_0=9, op_1=5, neg_sel=00.
  - 101 -> op_0=op_1=0.
- Backpressure: out_ready=0, push 3 beats A, B, C -> A and B are accepted and in_ready=0 after 2 pushes. Raise out_ready -> A, B, C appear in order, with C accepted on the cycle after in_ready returns to 1.
- Simultaneous push/pop at count=1 with continuous in_valid=out_ready=1 for 10 beats -> one output per cycle, in order, count stays at 1.
- flush asserted with count=2 and a concurrent push -> next cycle out_valid=0, in_ready=1, no entry emitted.
- rst_n pulsed low mid-stream -> outputs are 0 asynchronously and no stale beat appears after release.
